// File: rtl/demux_1_4_buffered.sv
// demux_1_4_buffered
//   Buffered 1:4 stream demultiplexer. One WIDTH-bit word per cycle enters on
//   a valid/ready input. in_sel steers it into one of four single-entry
//   holding registers. Each holding register drains through its own
//   valid/ready handshake. An 8-bit wrapping counter tracks accepted words.
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous reset, active-high
//   in_valid       producer offers in_data/in_sel
//   in_ready       block accepts the offered word this cycle (combinational)
//   in_data        input word, WIDTH bits
//   in_sel         destination channel 0..3
//   out_valid[k]   channel k holds a word
//   out_ready[k]   consumer k takes the word this cycle
//   out_data0..3   channel holding registers
//   accepted_cnt   input transfers since reset, modulo 256
module demux_1_4_buffered #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
  output logic [WIDTH-1:0] out_data3,
  output logic [7:0]       accepted_cnt
);

  logic [3:0]       valid_reg;
  logic [3:0]       valid_next;
  logic [WIDTH-1:0] data_reg  [4];
  logic [WIDTH-1:0] data_next [4];
  logic [3:0]       load;
  logic [7:0]       cnt_reg;
  logic [7:0]       cnt_next;
  logic             in_fire;

  // Only the selected channel decides readiness: a full channel that is
  // draining this cycle can take a new word, so throughput stays at one word
  // per cycle. A stalled selected channel blocks the input even if other
  // channels are empty (no reordering).
  assign in_ready = ~rst & (~valid_reg[in_sel] | out_ready[in_sel]);
  assign in_fire  = in_valid & in_ready;
  assign cnt_next = in_fire ? cnt_reg + 8'd1 : cnt_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_chan
      assign load[gi] = in_fire && (in_sel == 2'(gi));

      // A load wins over a drain: simultaneous drain and refill keeps the
      // channel full with the new word. Data is left untouched on a plain
      // drain; its value is meaningless while valid is low.
      assign valid_next[gi] = load[gi] | (valid_reg[gi] & ~out_ready[gi]);
      assign data_next[gi]  = load[gi] ? in_data : data_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= 4'b0000;
      cnt_reg   <= 8'd0;
      for (int i = 0; i < 4; i++) begin
        data_reg[i] <= '0;
      end
    end else begin
      valid_reg <= valid_next;
      cnt_reg   <= cnt_next;
      for (int i = 0; i < 4; i++) begin
        data_reg[i] <= data_next[i];
      end
    end
  end

  assign out_valid    = valid_reg;
  assign out_data0    = data_reg[0];
  assign out_data1    = data_reg[1];
  assign out_data2    = data_reg[2];
  assign out_data3    = data_reg[3];
  assign accepted_cnt = cnt_reg;

endmodule

// File: tb/tb_demux_1_4_buffered.sv
// Testbench for demux_1_4_buffered (WIDTH=4).
// Inputs change 1 time unit after a rising edge; in_ready is checked 1 unit
// after that, registered outputs 1 unit after the following rising edge.
module tb_demux_1_4_buffered;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic [1:0] in_sel;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic [3:0] out_data0, out_data1, out_data2, out_data3;
  logic [7:0] accepted_cnt;

  int total = 0;
  int bad   = 0;

  demux_1_4_buffered #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data0(out_data0), .out_data1(out_data1),
    .out_data2(out_data2), .out_data3(out_data3),
    .accepted_cnt(accepted_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       iv;
    logic [1:0] sel;
    logic [3:0] data;
    logic [3:0] ordy;
    logic       eir;
    logic [3:0] evld;
    logic [3:0] ed0, ed1, ed2, ed3;
    logic [7:0] ecnt;
  } vec_t;

  vec_t vecs [13];

  function automatic vec_t mk(logic r, logic iv, logic [1:0] s, logic [3:0] d,
                              logic [3:0] o, logic eir, logic [3:0] ev,
                              logic [3:0] e0, logic [3:0] e1, logic [3:0] e2,
                              logic [3:0] e3, logic [7:0] ec);
    vec_t v;
    v.rst = r; v.iv = iv; v.sel = s; v.data = d; v.ordy = o;
    v.eir = eir; v.evld = ev;
    v.ed0 = e0; v.ed1 = e1; v.ed2 = e2; v.ed3 = e3; v.ecnt = ec;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic iv, input logic [1:0] s,
                       input logic [3:0] d, input logic [3:0] o);
    rst = r; in_valid = iv; in_sel = s; in_data = d; out_ready = o;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sel = 2'd0; in_data = 4'd0; out_ready = 4'd0;

    //            rst iv sel data  ordy    | ir vld     d0    d1    d2    d3    cnt
    vecs[0]  = mk(1, 0, 0, 4'h0, 4'b0000, 0, 4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 8'd0);
    vecs[1]  = mk(0, 1, 0, 4'hA, 4'b0000, 1, 4'b0001, 4'hA, 4'h0, 4'h0, 4'h0, 8'd1);
    vecs[2]  = mk(0, 1, 1, 4'hB, 4'b0000, 1, 4'b0011, 4'hA, 4'hB, 4'h0, 4'h0, 8'd2);
    vecs[3]  = mk(0, 1, 2, 4'hC, 4'b0000, 1, 4'b0111, 4'hA, 4'hB, 4'hC, 4'h0, 8'd3);
    vecs[4]  = mk(0, 1, 3, 4'hD, 4'b0000, 1, 4'b1111, 4'hA, 4'hB, 4'hC, 4'hD, 8'd4);
    vecs[5]  = mk(0, 1, 2, 4'h9, 4'b0000, 0, 4'b1111, 4'hA, 4'hB, 4'hC, 4'hD, 8'd4);
    vecs[6]  = mk(0, 1, 2, 4'h9, 4'b0100, 1, 4'b1111, 4'hA, 4'hB, 4'h9, 4'hD, 8'd5);
    vecs[7]  = mk(0, 0, 0, 4'h0, 4'b1001, 1, 4'b0110, 4'hA, 4'hB, 4'h9, 4'hD, 8'd5);
    vecs[8]  = mk(0, 1, 1, 4'h6, 4'b0000, 0, 4'b0110, 4'hA, 4'hB, 4'h9, 4'hD, 8'd5);
    vecs[9]  = mk(0, 1, 3, 4'h6, 4'b0000, 1, 4'b1110, 4'hA, 4'hB, 4'h9, 4'h6, 8'd6);
    vecs[10] = mk(0, 1, 0, 4'hF, 4'b1111, 1, 4'b0001, 4'hF, 4'hB, 4'h9, 4'h6, 8'd7);
    vecs[11] = mk(1, 1, 1, 4'h3, 4'b0000, 0, 4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 8'd0);
    vecs[12] = mk(0, 1, 1, 4'h3, 4'b0000, 1, 4'b0010, 4'h0, 4'h3, 4'h0, 4'h0, 8'd1);

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].rst, vecs[i].iv, vecs[i].sel, vecs[i].data, vecs[i].ordy);
      chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(vecs[i].eir));
      tick();
      chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].evld));
      chk($sformatf("vec%0d out_data0", i), 32'(out_data0), 32'(vecs[i].ed0));
      chk($sformatf("vec%0d out_data1", i), 32'(out_data1), 32'(vecs[i].ed1));
      chk($sformatf("vec%0d out_data2", i), 32'(out_data2), 32'(vecs[i].ed2));
      chk($sformatf("vec%0d out_data3", i), 32'(out_data3), 32'(vecs[i].ed3));
      chk($sformatf("vec%0d accepted_cnt", i), 32'(accepted_cnt), 32'(vecs[i].ecnt));
      $display("vec %0d: rst=%0b iv=%0b sel=%0d data=%0h ordy=%b -> ir=%0b vld=%b cnt=%0d",
               i, vecs[i].rst, vecs[i].iv, vecs[i].sel, vecs[i].data, vecs[i].ordy,
               in_ready, out_valid, accepted_cnt);
    end

    // Stall on a full channel for 3 cycles, then drain-and-refill.
    drive(1, 0, 0, 4'h0, 4'b0000); tick();
    drive(0, 1, 2, 4'h5, 4'b0000); tick();
    for (int c = 0; c < 3; c++) begin
      drive(0, 1, 2, 4'h9, 4'b0000);
      chk("stall in_ready", 32'(in_ready), 32'd0);
      tick();
      chk("stall out_data2", 32'(out_data2), 32'h5);
      chk("stall out_valid", 32'(out_valid), 32'b0100);
      $display("stall cycle %0d: ir=%0b d2=%0h", c, in_ready, out_data2);
    end
    drive(0, 1, 2, 4'h9, 4'b0100);
    chk("refill in_ready", 32'(in_ready), 32'd1);
    tick();
    chk("refill out_data2", 32'(out_data2), 32'h9);
    chk("refill out_valid", 32'(out_valid), 32'b0100);
    chk("refill cnt", 32'(accepted_cnt), 32'd2);
    $display("refill: d2=%0h vld=%b cnt=%0d", out_data2, out_valid, accepted_cnt);

    // Head-of-line blocking: channel 1 stalled, channel 3 empty.
    drive(1, 0, 0, 4'h0, 4'b0000); tick();
    drive(0, 1, 1, 4'h7, 4'b0000); tick();
    drive(0, 1, 1, 4'h4, 4'b0000);
    chk("hol blocked in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("hol blocked out_valid", 32'(out_valid), 32'b0010);
    drive(0, 1, 3, 4'h4, 4'b0000);
    chk("hol redirect in_ready", 32'(in_ready), 32'd1);
    tick();
    chk("hol out_valid", 32'(out_valid), 32'b1010);
    chk("hol out_data3", 32'(out_data3), 32'h4);
    chk("hol out_data1", 32'(out_data1), 32'h7);
    $display("hol: vld=%b d1=%0h d3=%0h", out_valid, out_data1, out_data3);

    // Drain channels 0 and 3 together without refill.
    drive(1, 0, 0, 4'h0, 4'b0000); tick();
    drive(0, 1, 0, 4'h1, 4'b0000); tick();
    drive(0, 1, 3, 4'h2, 4'b0000); tick();
    chk("drain pre out_valid", 32'(out_valid), 32'b1001);
    drive(0, 0, 0, 4'h0, 4'b1001); tick();
    chk("drain post out_valid", 32'(out_valid), 32'b0000);
    drive(0, 0, 0, 4'h0, 4'b0000); tick();
    chk("drain idle out_valid", 32'(out_valid), 32'b0000);
    $display("drain: vld=%b", out_valid);

    // Streaming: 300 words into channel 0 with its consumer always ready.
    drive(1, 0, 0, 4'h0, 4'b0000); tick();
    for (int i = 0; i < 300; i++) begin
      drive(0, 1, 0, 4'(i), 4'b0001);
      chk("stream in_ready", 32'(in_ready), 32'd1);
      tick();
      chk("stream out_data0", 32'(out_data0), 32'(i % 16));
      chk("stream out_valid", 32'(out_valid), 32'b0001);
    end
    chk("stream cnt", 32'(accepted_cnt), 32'd44);
    $display("stream: 300 words, cnt=%0d", accepted_cnt);
    drive(0, 0, 0, 4'h0, 4'b0001); tick();
    chk("stream drained", 32'(out_valid), 32'b0000);

    // Reset mid-operation: three channels full, count 7.
    drive(1, 0, 0, 4'h0, 4'b0000); tick();
    drive(0, 1, 0, 4'h1, 4'b0000); tick();
    drive(0, 1, 1, 4'h2, 4'b0000); tick();
    drive(0, 1, 2, 4'h3, 4'b0000); tick();
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 3, 4'(8 + i), 4'b1000); tick();
    end
    drive(0, 0, 0, 4'h0, 4'b1000); tick();
    chk("midrst pre out_valid", 32'(out_valid), 32'b0111);
    chk("midrst pre cnt", 32'(accepted_cnt), 32'd7);
    drive(1, 1, 3, 4'h5, 4'b0000);
    chk("midrst in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("midrst out_valid", 32'(out_valid), 32'b0000);
    chk("midrst data", {16'd0, out_data3, out_data2, out_data1, out_data0}, 32'd0);
    chk("midrst cnt", 32'(accepted_cnt), 32'd0);
    drive(0, 1, 3, 4'h5, 4'b0000);
    chk("postrst in_ready", 32'(in_ready), 32'd1);
    tick();
    chk("postrst out_valid", 32'(out_valid), 32'b1000);
    chk("postrst out_data3", 32'(out_data3), 32'h5);
    chk("postrst cnt", 32'(accepted_cnt), 32'd1);
    $display("midrst: vld=%b d3=%0h cnt=%0d", out_valid, out_data3, accepted_cnt);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
